// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage with PC generation, credit-limited pipelined imem
// requests, pc-tag FIFO, prefetch queue and redirect flush/drop handling.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (trap on misaligned redirect
// targets instead of forcing them to word alignment).

module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     CNT_W    = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_fault
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] tag_wr;
  logic [PTR_W-1:0] tag_rd;
  logic [PTR_W-1:0] q_head;
  logic [PTR_W-1:0] q_tail;
  logic [XLEN-1:0]  tag_mem [QDEPTH];
  logic [XLEN-1:0]  q_pc    [QDEPTH];
  logic [XLEN-1:0]  q_instr [QDEPTH];

  logic [XLEN-1:0]  redir_target;
  logic             redir_misalign;
  logic             halted;
  logic [SUM_W-1:0] credit_used;
  logic             req_fire;
  logic             rsp_drop;
  logic             push;
  logic             pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic q_fault [QDEPTH];

  assign redir_target   = redirect_pc;
  assign redir_misalign = (redirect_pc[1:0] != 2'b00);
  assign if_fault       = if_valid && q_fault[q_head];
`else
  logic unused_redirect_lsb;

  assign redir_target        = {redirect_pc[XLEN-1:2], 2'b00};
  assign redir_misalign      = 1'b0;
  assign halted              = 1'b0;
  assign if_fault            = 1'b0;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  // Issue control: every request reserves a queue slot until its entry is popped
  assign credit_used    = SUM_W'(count) + SUM_W'(outstanding);
  assign imem_req_valid = !reset && !redirect_valid && !halted &&
                          (credit_used < SUM_W'(QDEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Response and queue handshakes; a redirect discards the same-cycle response and pop
  assign rsp_drop         = (drop != '0);
  assign push             = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign pop              = if_valid && if_ready && !redirect_valid;
  assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

  // Head of the registered queue presented to ID
  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? q_pc[q_head]    : '0;
  assign if_instr = if_valid ? q_instr[q_head] : '0;

  // Control state: PC, counters, pointers, redirect flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      q_head      <= '0;
      q_tail      <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted      <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding_next;
      if (req_fire)       tag_wr <= tag_wr + PTR_W'(1);
      if (imem_rsp_valid) tag_rd <= tag_rd + PTR_W'(1);
      if (redirect_valid) begin
        fetch_pc <= redir_target;
        drop     <= outstanding_next;
        q_head   <= '0;
        if (redir_misalign) begin
          q_tail <= PTR_W'(1);
          count  <= CNT_W'(1);
        end else begin
          q_tail <= '0;
          count  <= '0;
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        halted <= redir_misalign;
`endif
      end else begin
        if (req_fire)                fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid && rsp_drop) drop  <= drop - CNT_W'(1);
        if (push) q_tail <= q_tail + PTR_W'(1);
        if (pop)  q_head <= q_head + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  // Storage arrays: pc tags for in-flight requests and the prefetch queue payload
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (redirect_valid && redir_misalign) begin
      q_pc[0]    <= redirect_pc;
      q_instr[0] <= '0;
      q_fault[0] <= 1'b1;
    end else if (push) begin
      q_pc[q_tail]    <= tag_mem[tag_rd];
      q_instr[q_tail] <= imem_rsp_data;
      q_fault[q_tail] <= 1'b0;
    end
`else
    if (push) begin
      q_pc[q_tail]    <= tag_mem[tag_rd];
      q_instr[q_tail] <= imem_rsp_data;
    end
`endif
  end

  // A response must always belong to an accepted request
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && outstanding == '0))
        else $error("imem response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency memory model.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int n_acc  = 0;
  int acc_base;

  logic        pv [8];
  logic [31:0] pa [8];

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: always ready, in-order response exactly lat cycles after acceptance
  assign imem_req_ready = 1'b1;
  assign imem_rsp_valid = pv[0];
  assign imem_rsp_data  = mem_word(pa[0]);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[7] <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= imem_req_addr;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) n_acc <= n_acc + 1;
  end

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    lat            = 1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_b("rst_if_valid", if_valid, 1'b0);
    chk_b("rst_req_valid", imem_req_valid, 1'b0);
    chk_w("rst_if_pc", if_pc, 32'h0);
    chk_w("rst_if_instr", if_instr, 32'h0);
    chk_b("rst_if_fault", if_fault, 1'b0);

    // Streaming with 1-cycle memory: first entry two cycles after release
    reset    = 1'b0;
    if_ready = 1'b1;
    chk_w("first_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    chk_b("first_latency", if_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_b("stream_valid", if_valid, 1'b1);
      chk_w("stream_pc", if_pc, 32'(i * 4));
      chk_w("stream_instr", if_instr, mem_word(32'(i * 4)));
    end

    // Back-pressure for 10 cycles: head stays at 'h10, queue fills to 4
    if_ready = 1'b0;
    acc_base = n_acc;
    repeat (10) @(negedge clk);
    chk_w("bp_accepts", 32'(n_acc - acc_base), 32'd2);
    chk_b("bp_req_stopped", imem_req_valid, 1'b0);
    chk_b("bp_head_valid", if_valid, 1'b1);
    chk_w("bp_head_pc", if_pc, 32'h10);
    if_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk_b("drain_valid", if_valid, 1'b1);
      chk_w("drain_pc", if_pc, 32'(32'h10 + i * 4));
    end

    // Latency 3: redirect while 0,4,8 are in flight (0 arriving this cycle)
    reset = 1'b1;
    lat   = 3;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_b("l3_rsp_arriving", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk_b("l3_no_req_in_redirect", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk_b("l3_req_valid", imem_req_valid, 1'b1);
    chk_w("l3_req_addr", imem_req_addr, 32'h100);
    chk_b("l3_no_stale0", if_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b("l3_no_stale", if_valid, 1'b0);
    end
    @(negedge clk);
    chk_b("l3_new_valid", if_valid, 1'b1);
    chk_w("l3_new_pc", if_pc, 32'h100);
    chk_w("l3_new_instr", if_instr, mem_word(32'h100));
    @(negedge clk);
    chk_w("l3_next_pc", if_pc, 32'h104);

    // Redirect coinciding with a response and a pop
    reset = 1'b1;
    lat   = 1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_w("co_head_pc", if_pc, 32'h0);
    chk_b("co_rsp_arriving", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk_b("co_pop_pending", if_valid, 1'b1);
    chk_b("co_no_req", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk_b("co_queue_empty", if_valid, 1'b0);
    chk_w("co_req_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    chk_w("co_pc_after_accept", imem_req_addr, 32'h104);
    @(negedge clk);
    chk_w("co_head_new", if_pc, 32'h100);

    // PC wrap from 'hFFFF_FFFC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk_w("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk_w("wrap_req_zero", imem_req_addr, 32'h0);
    @(negedge clk);
    chk_w("wrap_head_top", if_pc, 32'hFFFF_FFFC);
    chk_w("wrap_instr_top", if_instr, mem_word(32'hFFFF_FFFC));
    @(negedge clk);
    chk_w("wrap_head_zero", if_pc, 32'h0);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk_b("mis_valid", if_valid, 1'b1);
    chk_w("mis_pc", if_pc, 32'h102);
    chk_b("mis_fault", if_fault, 1'b1);
    chk_w("mis_instr", if_instr, 32'h0);
    chk_b("mis_no_req", imem_req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b("mis_halted", imem_req_valid, 1'b0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk_b("mis_resume_valid", imem_req_valid, 1'b1);
    chk_w("mis_resume_addr", imem_req_addr, 32'h200);
`else
    chk_b("mis_req_valid", imem_req_valid, 1'b1);
    chk_w("mis_req_addr", imem_req_addr, 32'h100);
    chk_b("mis_queue_empty", if_valid, 1'b0);
    chk_b("mis_no_fault", if_fault, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
